egress_arbiter: RTL and testbench



---
 rtl/egress_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_egress_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_arbiter.sv
// egress_arbiter: packet-granular round-robin arbiter that moves whole packets
// from three non-showahead ingress FIFOs into the output buffer write port.
// One word is in flight at a time: POP issues the read, WRITE stores the word.
// Every output is registered; the combinational process computes next values.
module egress_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_q0,
    input  logic [DATA_W-1:0] fifo_q1,
    input  logic [DATA_W-1:0] fifo_q2,
    input  logic              out_full,
    output logic [2:0]        fifo_rd,
    output logic              out_wr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              pkt_done,
    output logic              err
);

    // Stall counter value at which the next blocked POP cycle aborts the packet.
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          owner;
    logic [1:0]          owner_nxt;
    logic [1:0]          rr_ptr;
    logic [1:0]          rr_nxt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   wr_ptr_nxt;
    logic [LEN_W-1:0]    remaining;
    logic [LEN_W-1:0]    remaining_nxt;
    logic                hdr_pending;
    logic                hdr_pending_nxt;
    logic [7:0]          stall_cnt;
    logic [7:0]          stall_nxt;

    logic [2:0]          grant_nxt;
    logic [2:0]          fifo_rd_nxt;
    logic                busy_nxt;
    logic                out_wr_nxt;
    logic [ADDR_W-1:0]   out_addr_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                pkt_done_nxt;
    logic                err_nxt;

    logic [DATA_W-1:0]   owner_q;
    logic                last_word;

    // Successor of an input index in the fixed ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First requesting input, scanning start, start+1, start+2 (mod 3).
    function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [2:0] req);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        cand  = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = inc3(cand);
        end
        return pick;
    endfunction

    // Read data of the current owner.
    always_comb begin
        owner_q = fifo_q2;
        case (owner)
            2'd0:    owner_q = fifo_q0;
            2'd1:    owner_q = fifo_q1;
            default: owner_q = fifo_q2;
        endcase
    end

    // Last-word detection: header with zero length, or payload with one word left.
    always_comb begin
        last_word = hdr_pending ? (owner_q[LEN_W-1:0] == '0) : (remaining == {{(LEN_W-1){1'b0}}, 1'b1});
    end

    // Next-state and next-output logic; pulse outputs default low every cycle.
    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        rr_nxt          = rr_ptr;
        wr_ptr_nxt      = wr_ptr;
        remaining_nxt   = remaining;
        hdr_pending_nxt = hdr_pending;
        stall_nxt       = stall_cnt;
        grant_nxt       = grant;
        busy_nxt        = busy;
        fifo_rd_nxt     = 3'b000;
        out_wr_nxt      = 1'b0;
        out_addr_nxt    = out_addr;
        out_data_nxt    = out_data;
        pkt_done_nxt    = 1'b0;
        err_nxt         = 1'b0;

        case (state)
            IDLE: begin
                if (enable && (fifo_empty != 3'b111)) begin
                    owner_nxt       = rr_pick(rr_ptr, ~fifo_empty);
                    grant_nxt       = 3'b001 << rr_pick(rr_ptr, ~fifo_empty);
                    busy_nxt        = 1'b1;
                    hdr_pending_nxt = 1'b1;
                    stall_nxt       = 8'd0;
                    state_nxt       = POP;
                end
            end

            POP: begin
                if (!fifo_empty[owner] && !out_full) begin
                    fifo_rd_nxt = grant;
                    stall_nxt   = 8'd0;
                    state_nxt   = WRITE;
                end else if (fifo_empty[owner]) begin
                    // Starved mid-packet: count, and give up after TIMEOUT cycles.
                    if (stall_cnt == STALL_LAST) begin
                        err_nxt   = 1'b1;
                        rr_nxt    = inc3(owner);
                        grant_nxt = 3'b000;
                        busy_nxt  = 1'b0;
                        stall_nxt = 8'd0;
                        state_nxt = IDLE;
                    end else begin
                        stall_nxt = stall_cnt + 8'd1;
                    end
                end
                // Blocked only by out_full: hold everything, including stall_cnt.
            end

            WRITE: begin
                out_wr_nxt   = 1'b1;
                out_data_nxt = owner_q;
                out_addr_nxt = wr_ptr;
                wr_ptr_nxt   = wr_ptr + 1'b1;
                if (hdr_pending) begin
                    remaining_nxt   = owner_q[LEN_W-1:0];
                    hdr_pending_nxt = 1'b0;
                end else begin
                    remaining_nxt = remaining - 1'b1;
                end
                if (last_word) begin
                    pkt_done_nxt = 1'b1;
                    rr_nxt       = inc3(owner);
                    grant_nxt    = 3'b000;
                    busy_nxt     = 1'b0;
                    state_nxt    = IDLE;
                end else begin
                    state_nxt = POP;
                end
            end

            default: begin
                grant_nxt = 3'b000;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 2'd0;
            rr_ptr      <= 2'd0;
            wr_ptr      <= '0;
            remaining   <= '0;
            hdr_pending <= 1'b0;
            stall_cnt   <= 8'd0;
            grant       <= 3'b000;
            busy        <= 1'b0;
            fifo_rd     <= 3'b000;
            out_wr      <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
            pkt_done    <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            remaining   <= remaining_nxt;
            hdr_pending <= hdr_pending_nxt;
            stall_cnt   <= stall_nxt;
            grant       <= grant_nxt;
            busy        <= busy_nxt;
            fifo_rd     <= fifo_rd_nxt;
            out_wr      <= out_wr_nxt;
            out_addr    <= out_addr_nxt;
            out_data    <= out_data_nxt;
            pkt_done    <= pkt_done_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// Testbench for egress_arbiter: three FIFO models feed the DUT, a scoreboard
// queue holds the expected buffer writes in order, and directed scenarios
// exercise single packets, round robin, backpressure, underrun, wrap and reset.
module tb_egress_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [2:0]        fifo_empty;
    logic [DATA_W-1:0] fifo_q0;
    logic [DATA_W-1:0] fifo_q1;
    logic [DATA_W-1:0] fifo_q2;
    logic              out_full;
    logic [2:0]        fifo_rd;
    logic              out_wr;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        grant;
    logic              busy;
    logic              pkt_done;
    logic              err;

    always #5 clk = ~clk;

    egress_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_q0   (fifo_q0),
        .fifo_q1   (fifo_q1),
        .fifo_q2   (fifo_q2),
        .out_full  (out_full),
        .fifo_rd   (fifo_rd),
        .out_wr    (out_wr),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .grant     (grant),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .err       (err)
    );

    // FIFO models: stimulus appends words, reads pop on the negedge of the read cycle.
    logic [DATA_W-1:0] mem [3][256];
    int                wcnt [3] = '{0, 0, 0};
    int                rcnt [3] = '{0, 0, 0};
    logic [DATA_W-1:0] fq [3] = '{'0, '0, '0};
    logic              flush = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                rcnt[i] <= wcnt[i];
            end else if (fifo_rd[i] && (rcnt[i] != wcnt[i])) begin
                fq[i]   <= mem[i][rcnt[i] % 256];
                rcnt[i] <= rcnt[i] + 1;
            end
        end
    end

    always_comb begin
        fifo_empty = 3'b111;
        for (int i = 0; i < 3; i++) fifo_empty[i] = (rcnt[i] == wcnt[i]);
    end

    assign fifo_q0 = fq[0];
    assign fifo_q1 = fq[1];
    assign fifo_q2 = fq[2];

    // Scoreboard and bookkeeping.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                src;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    int                n_total = 0;
    int                n_pass = 0;
    int                cyc = 0;
    int                done_cnt, err_cnt, full_viol, both_viol;
    int                first_grant_cyc, done_cyc, err_cyc;
    logic [2:0]        first_grant_val;
    logic [2:0]        prev_grant = 3'b000;
    int                rd_cycs[$];
    int                wr_cycs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic clr_rec();
        rd_cycs.delete();
        wr_cycs.delete();
        first_grant_cyc = -1;
        first_grant_val = 3'b000;
        done_cyc  = -1;
        err_cyc   = -1;
        done_cnt  = 0;
        err_cnt   = 0;
        full_viol = 0;
        both_viol = 0;
    endtask

    task automatic load(input int i, input logic [DATA_W-1:0] w);
        mem[i][wcnt[i] % 256] = w;
        wcnt[i] = wcnt[i] + 1;
    endtask

    task automatic expect_w(input int src, input logic [DATA_W-1:0] w);
        exp_t e;
        e.addr = exp_addr;
        e.data = w;
        e.src  = src;
        exp_q.push_back(e);
        exp_addr = exp_addr + 1'b1;
    endtask

    // Header with length len followed by npay payload words; every loaded word is expected out.
    task automatic pkt(input int i, input int seq, input int len, input int npay);
        logic [DATA_W-1:0] w;
        w = 32'h4800_0000 | (32'(i) << 16) | (32'(seq) << 8) | 32'(len);
        load(i, w);
        expect_w(i, w);
        for (int k = 0; k < npay; k++) begin
            w = 32'hD000_0000 | (32'(i) << 16) | (32'(seq) << 8) | 32'(k);
            load(i, w);
            expect_w(i, w);
        end
    endtask

    // One clock: sample outputs on the negedge, score them, then step off the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (grant != 3'b000 && prev_grant == 3'b000 && first_grant_cyc < 0) begin
            first_grant_cyc = cyc;
            first_grant_val = grant;
        end
        prev_grant = grant;
        if (fifo_rd != 3'b000) begin
            rd_cycs.push_back(cyc);
            if (exp_q.size() > 0) chk("rd_src", 32'(fifo_rd), 32'(1) << exp_q[0].src);
            chk("rd_vs_grant", 32'(fifo_rd), 32'(grant));
        end
        if (out_wr) begin
            wr_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("extra_wr", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(out_addr), 32'(e.addr));
                chk("wr_data", out_data, e.data);
            end
        end
        if (pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (pkt_done && err) both_viol++;
        if (out_full && (fifo_rd != 3'b000 || out_wr)) full_viol++;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        exp_addr = '0;
        tick();
        tick();
        flush = 1'b0;
        reset = 1'b0;
        clr_rec();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fifo_rd"},  32'(fifo_rd),  32'd0);
        chk({tag, "_out_wr"},   32'(out_wr),   32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_out_data"}, out_data,      32'd0);
        chk({tag, "_grant"},    32'(grant),    32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
    endtask

    // Run until every expected word is written and the arbiter is idle, then idle a little more.
    task automatic wait_drain(input string tag, input int limit);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < limit) begin
            tick();
            k++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size() != 0 || busy), 32'd0);
        for (int j = 0; j < 4; j++) tick();
        chk({tag, "_no_both"}, 32'(both_viol), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (wr_cycs.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk({tag, "_reached"}, 32'(wr_cycs.size() >= n), 32'd1);
    endtask

    // Directed scenarios.
    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        out_full = 1'b0;
        clr_rec();

        // Reset state.
        apply_reset();
        reset = 1'b1;
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        clr_rec();

        // Single packet from input 1: header length 2 plus two payload words.
        pkt(1, 1, 2, 2);
        wait_drain("single", 100);
        chk("single_grant", 32'(first_grant_val), 32'b010);
        chk("single_nrd", 32'(rd_cycs.size()), 32'd3);
        chk("single_nwr", 32'(wr_cycs.size()), 32'd3);
        if (rd_cycs.size() == 3 && wr_cycs.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("single_rd_cyc", 32'(rd_cycs[k] - first_grant_cyc), 32'(2 * k + 1));
                chk("single_wr_cyc", 32'(wr_cycs[k] - first_grant_cyc), 32'(2 * k + 2));
            end
        end
        chk("single_done_cyc", 32'(done_cyc - first_grant_cyc), 32'd6);
        chk("single_done_cnt", 32'(done_cnt), 32'd1);
        chk("single_err_cnt", 32'(err_cnt), 32'd0);

        // Round robin: two zero-length packets on every input, expected order 0,1,2,0,1,2.
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) pkt(i, 10 + r, 0, 0);
        wait_drain("rr", 200);
        chk("rr_done_cnt", 32'(done_cnt), 32'd6);
        chk("rr_err_cnt", 32'(err_cnt), 32'd0);
        chk("rr_nwr", 32'(wr_cycs.size()), 32'd6);

        // Backpressure: out_full held for 5 cycles during the payload of a length-3 packet.
        apply_reset();
        pkt(0, 20, 3, 3);
        wait_writes("bp_pre", 2, 50);
        out_full = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        out_full = 1'b0;
        wait_drain("bp", 100);
        chk("bp_full_viol", 32'(full_viol), 32'd0);
        chk("bp_err_cnt", 32'(err_cnt), 32'd0);
        chk("bp_nwr", 32'(wr_cycs.size()), 32'd4);
        chk("bp_duration", 32'(done_cyc - first_grant_cyc), 32'(2 * 3 + 2 + 5));

        // Underrun: length 4 with only 2 payload words; input 2 waits behind it.
        apply_reset();
        pkt(1, 30, 4, 2);
        pkt(2, 31, 0, 0);
        wait_drain("ur", 200);
        chk("ur_err_cnt", 32'(err_cnt), 32'd1);
        chk("ur_done_cnt", 32'(done_cnt), 32'd1);
        chk("ur_nwr", 32'(wr_cycs.size()), 32'd4);
        if (wr_cycs.size() == 4) begin
            chk("ur_err_delay", 32'(err_cyc - wr_cycs[2]), 32'(TIMEOUT));
            chk("ur_err_before_next", 32'(err_cyc < wr_cycs[3]), 32'd1);
        end

        // Wrap: 20 words through a 16-entry address space.
        apply_reset();
        for (int s = 0; s < 4; s++) pkt(0, 40 + s, 4, 4);
        wait_drain("wrap", 300);
        chk("wrap_nwr", 32'(wr_cycs.size()), 32'd20);
        chk("wrap_done_cnt", 32'(done_cnt), 32'd4);
        chk("wrap_last_addr", 32'(out_addr), 32'd3);

        // Reset in the middle of an input-2 packet, after input 0 has moved the pointer.
        apply_reset();
        pkt(0, 50, 0, 0);
        wait_drain("mid_a", 50);
        pkt(2, 51, 3, 3);
        wait_writes("mid_b", 3, 50);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check_reset_outputs("mid_rst");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        reset = 1'b0;
        exp_addr = '0;
        clr_rec();
        pkt(0, 52, 0, 0);
        pkt(2, 53, 0, 0);
        wait_drain("mid_c", 100);
        chk("mid_first_grant", 32'(first_grant_val), 32'b001);
        chk("mid_done_cnt", 32'(done_cnt), 32'd2);
        chk("mid_err_cnt", 32'(err_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: the directed sequence needs only a few thousand cycles.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
